// File: rtl/regfile_wb_sequencer_if.sv
// Bus between the two write-back requesters, the sequencer and the register file.
// Requesters/register-file side uses the master modport; the sequencer uses slave.
interface regfile_wb_sequencer_if #(
  parameter int DATA_W  = 16,
  parameter int NIB_CNT = 4,
  parameter int ADDR_W  = 4
);
  logic [1:0]         req_valid;
  logic [ADDR_W-1:0]  req_addr0;
  logic [DATA_W-1:0]  req_data0;
  logic [NIB_CNT-1:0] req_mask0;
  logic [ADDR_W-1:0]  req_addr1;
  logic [DATA_W-1:0]  req_data1;
  logic [NIB_CNT-1:0] req_mask1;
  logic [1:0]         req_ready;
  logic [1:0]         done;
  logic               busy;
  logic               err_addr;
  logic               rf_write;
  logic [ADDR_W-1:0]  rf_write_reg;
  logic [DATA_W-1:0]  rf_write_data;
  logic [1:0]         rf_quarter;

  modport master (
    output req_valid, req_addr0, req_data0, req_mask0,
    output req_addr1, req_data1, req_mask1,
    input  req_ready, done, busy, err_addr,
    input  rf_write, rf_write_reg, rf_write_data, rf_quarter
  );

  modport slave (
    input  req_valid, req_addr0, req_data0, req_mask0,
    input  req_addr1, req_data1, req_mask1,
    output req_ready, done, busy, err_addr,
    output rf_write, rf_write_reg, rf_write_data, rf_quarter
  );
endinterface

// File: rtl/regfile_wb_sequencer.sv
// Write-back sequencer: arbitrates ALU/load writes and issues them as masked nibble writes.
// Define WB_FIXED_PRIO_EN to make the load port always win contention (default round-robin).
module regfile_wb_sequencer #(
  parameter int DATA_W  = 16,
  parameter int NIB_CNT = 4,
  parameter int ADDR_W  = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  regfile_wb_sequencer_if.slave wb
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t             state, state_n;
  logic               last_grant, last_grant_n;
  logic               grant, grant_n;
  logic [ADDR_W-1:0]  lat_addr, lat_addr_n;
  logic [DATA_W-1:0]  lat_data, lat_data_n;
  logic [NIB_CNT-1:0] mask_rem, mask_rem_n;
  logic               err_q, err_n;
  logic [1:0]         done_q, done_n;
  logic               rf_write_q, rf_write_n;
  logic [ADDR_W-1:0]  rf_write_reg_q, rf_write_reg_n;
  logic [DATA_W-1:0]  rf_write_data_q, rf_write_data_n;
  logic [1:0]         rf_quarter_q, rf_quarter_n;

  logic               sel;
  logic [1:0]         ready;
  logic               issue;
  logic [1:0]         nib_idx;
  logic [ADDR_W-1:0]  src_addr;
  logic [DATA_W-1:0]  src_data;
  logic [NIB_CNT-1:0] src_mask;

  function automatic logic [1:0] lowest_nib(input logic [NIB_CNT-1:0] m);
    lowest_nib = '0;
    for (int i = NIB_CNT - 1; i >= 0; i--) begin
      if (m[i]) lowest_nib = 2'(i);
    end
  endfunction

  always_comb begin
    sel   = 1'b0;
    ready = 2'b00;
    unique case (wb.req_valid)
      2'b01: sel = 1'b0;
      2'b10: sel = 1'b1;
      2'b11: begin
`ifdef WB_FIXED_PRIO_EN
        sel = 1'b1;
`else
        sel = ~last_grant;
`endif
      end
      default: sel = 1'b0;
    endcase
    if (state == IDLE && wb.req_valid != 2'b00) ready[sel] = 1'b1;
  end

  // The accept cycle and every WRITE cycle share one issue path, so the
  // first nibble is registered on the accept edge itself.
  always_comb begin
    state_n         = state;
    last_grant_n    = last_grant;
    grant_n         = grant;
    lat_addr_n      = lat_addr;
    lat_data_n      = lat_data;
    mask_rem_n      = mask_rem;
    err_n           = err_q;
    done_n          = 2'b00;
    rf_write_n      = 1'b0;
    rf_write_reg_n  = '0;
    rf_write_data_n = '0;
    rf_quarter_n    = 2'b00;
    src_addr        = lat_addr;
    src_data        = lat_data;
    src_mask        = mask_rem;
    issue           = 1'b0;
    nib_idx         = 2'b00;

    unique case (state)
      IDLE: begin
        if ((wb.req_valid & ready) != 2'b00) begin
          grant_n      = sel;
          last_grant_n = sel;
          issue        = 1'b1;
          src_addr     = sel ? wb.req_addr1 : wb.req_addr0;
          src_data     = sel ? wb.req_data1 : wb.req_data0;
          src_mask     = sel ? wb.req_mask1 : wb.req_mask0;
          lat_addr_n   = src_addr;
          lat_data_n   = src_data;
          if (src_addr > ADDR_W'(7)) err_n = 1'b1;
        end
      end
      WRITE:   issue   = 1'b1;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (issue) begin
      if (src_mask == '0) begin
        state_n          = DONE;
        done_n[grant_n]  = 1'b1;
      end else begin
        nib_idx             = lowest_nib(src_mask);
        rf_write_n          = 1'b1;
        rf_quarter_n        = nib_idx;
        rf_write_reg_n      = src_addr;
        rf_write_data_n     = DATA_W'(src_data[4*nib_idx +: 4]);
        mask_rem_n          = src_mask;
        mask_rem_n[nib_idx] = 1'b0;
        state_n             = WRITE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      last_grant      <= 1'b1;
      grant           <= 1'b0;
      lat_addr        <= '0;
      lat_data        <= '0;
      mask_rem        <= '0;
      err_q           <= 1'b0;
      done_q          <= 2'b00;
      rf_write_q      <= 1'b0;
      rf_write_reg_q  <= '0;
      rf_write_data_q <= '0;
      rf_quarter_q    <= 2'b00;
    end else begin
      state           <= state_n;
      last_grant      <= last_grant_n;
      grant           <= grant_n;
      lat_addr        <= lat_addr_n;
      lat_data        <= lat_data_n;
      mask_rem        <= mask_rem_n;
      err_q           <= err_n;
      done_q          <= done_n;
      rf_write_q      <= rf_write_n;
      rf_write_reg_q  <= rf_write_reg_n;
      rf_write_data_q <= rf_write_data_n;
      rf_quarter_q    <= rf_quarter_n;
    end
  end

  assign wb.req_ready     = ready;
  assign wb.done          = done_q;
  assign wb.busy          = (state != IDLE);
  assign wb.err_addr      = err_q;
  assign wb.rf_write      = rf_write_q;
  assign wb.rf_write_reg  = rf_write_reg_q;
  assign wb.rf_write_data = rf_write_data_q;
  assign wb.rf_quarter    = rf_quarter_q;

endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// Bench for regfile_wb_sequencer: directed scenarios plus random requests checked
// against a transaction-level model and a nibble-writable register file model.
module tb_regfile_wb_sequencer;
  localparam int DATA_W  = 16;
  localparam int NIB_CNT = 4;
  localparam int ADDR_W  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  regfile_wb_sequencer_if #(.DATA_W(DATA_W), .NIB_CNT(NIB_CNT), .ADDR_W(ADDR_W)) wb ();

  regfile_wb_sequencer #(.DATA_W(DATA_W), .NIB_CNT(NIB_CNT), .ADDR_W(ADDR_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .wb   (wb)
  );

  always #5 clk = ~clk;

  // Register file driven by the DUT; it ignores addresses 8-15.
  logic [15:0] rf_mem [8] = '{default: 16'h0000};
  always @(posedge clk) begin
    if (wb.rf_write && wb.rf_write_reg < 4'd8)
      rf_mem[wb.rf_write_reg[2:0]][4*wb.rf_quarter +: 4] <= wb.rf_write_data[3:0];
  end

  logic [15:0] exp_mem [8] = '{default: 16'h0000};
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [1:0]  pend_valid = 2'b00;
  logic [3:0]  pend_addr [2];
  logic [15:0] pend_data [2];
  logic [3:0]  pend_mask [2];
  int          model_last = 1;
  logic        err_exp = 1'b0;

`ifdef WB_FIXED_PRIO_EN
  int exp_order [4] = '{1, 1, 1, 1};
`else
  int exp_order [4] = '{0, 1, 0, 1};
`endif

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input int port, input logic [3:0] a, input logic [15:0] d,
                               input logic [3:0] m);
    pend_valid[port] = 1'b1;
    pend_addr[port]  = a;
    pend_data[port]  = d;
    pend_mask[port]  = m;
    if (port == 0) begin
      wb.req_addr0 = a;
      wb.req_data0 = d;
      wb.req_mask0 = m;
    end else begin
      wb.req_addr1 = a;
      wb.req_data1 = d;
      wb.req_mask1 = m;
    end
    wb.req_valid[port] = 1'b1;
  endtask

  function automatic int pick_winner();
    if (pend_valid == 2'b01) return 0;
    if (pend_valid == 2'b10) return 1;
`ifdef WB_FIXED_PRIO_EN
    return 1;
`else
    return 1 - model_last;
`endif
  endfunction

  task automatic wait_ready(input int port, output int waited, output bit ok);
    int n = 0;
    #1;
    while (wb.req_ready == 2'b00 && n < 20) begin
      @(negedge clk); #1;
      n++;
      checkOutput("idle_done_low", wb.done, 0);
      checkOutput("idle_reg_zero", wb.rf_write_reg, 0);
    end
    checkOutput("grant", wb.req_ready, 32'(1 << port));
    waited = n;
    ok     = (wb.req_ready == 2'(1 << port));
  endtask

  // One complete transaction: grant, per-nibble writes in ascending quarter order, done pulse.
  task automatic run_next(input bit hold, output int waited, output int port);
    logic [3:0]  a, m;
    logic [15:0] d;
    bit          ok;
    port = pick_winner();
    a = pend_addr[port];
    d = pend_data[port];
    m = pend_mask[port];
    wait_ready(port, waited, ok);
    if (!ok) return;
    @(posedge clk);
    model_last = port;
    if (a >= 4'd8) err_exp = 1'b1;
    #1;
    if (!hold) wb.req_valid[port] = 1'b0;
    pend_valid[port] = 1'b0;
    for (int q = 0; q < 4; q++) begin
      if (m[q]) begin
        @(negedge clk);
        checkOutput("wr_strobe", wb.rf_write, 1);
        checkOutput("wr_quarter", wb.rf_quarter, q);
        checkOutput("wr_data", wb.rf_write_data, {12'h000, d[4*q +: 4]});
        checkOutput("wr_reg", wb.rf_write_reg, a);
        checkOutput("wr_busy", wb.busy, 1);
        checkOutput("wr_ready_low", wb.req_ready, 0);
        checkOutput("wr_no_done", wb.done, 0);
      end
    end
    @(negedge clk);
    checkOutput("done_pulse", wb.done, 32'(1 << port));
    checkOutput("done_no_write", wb.rf_write, 0);
    checkOutput("err_addr", wb.err_addr, err_exp);
    if (a < 4'd8) begin
      for (int q = 0; q < 4; q++)
        if (m[q]) exp_mem[a[2:0]][4*q +: 4] = d[4*q +: 4];
      checkOutput("rf_contents", rf_mem[a[2:0]], exp_mem[a[2:0]]);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  w, p;
    bit  ok;
    wb.req_valid = 2'b00;
    wb.req_addr0 = '0; wb.req_data0 = '0; wb.req_mask0 = '0;
    wb.req_addr1 = '0; wb.req_data1 = '0; wb.req_mask1 = '0;
    #2;
    checkOutput("rst_write", wb.rf_write, 0);
    checkOutput("rst_reg", wb.rf_write_reg, 0);
    checkOutput("rst_data", wb.rf_write_data, 0);
    checkOutput("rst_quarter", wb.rf_quarter, 0);
    checkOutput("rst_done", wb.done, 0);
    checkOutput("rst_busy", wb.busy, 0);
    checkOutput("rst_err", wb.err_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] single full write");
    applyStimulus(0, 4'd2, 16'hA5C3, 4'hF);
    run_next(1'b0, w, p);
    checkOutput("reg2_value", rf_mem[2], 16'hA5C3);

    $display("[TB] sparse mask");
    applyStimulus(1, 4'd7, 16'h1234, 4'b1010);
    run_next(1'b0, w, p);
    checkOutput("reg7_value", rf_mem[7], 16'h1030);

    $display("[TB] contention");
    for (int r = 0; r < 4; r++) begin
      for (int q = 0; q < 2; q++)
        if (!pend_valid[q]) applyStimulus(q, 4'($urandom_range(0, 7)), 16'($urandom), 4'hF);
      run_next(1'b0, w, p);
      checkOutput("contention_order", p, exp_order[r]);
    end
    for (int k = 0; k < 2 && pend_valid != 2'b00; k++) run_next(1'b0, w, p);

    $display("[TB] empty mask, bad address");
    applyStimulus(0, 4'd9, 16'h5A5A, 4'h0);
    run_next(1'b0, w, p);

    $display("[TB] back-to-back");
    applyStimulus(0, 4'd5, 16'($urandom), 4'hF);
    run_next(1'b1, w, p);
    applyStimulus(0, 4'd6, 16'($urandom), 4'b0110);
    run_next(1'b0, w, p);
    checkOutput("b2b_gap", w, 1);

    $display("[TB] reset mid-sequence");
    applyStimulus(0, 4'd3, 16'hBEEF, 4'hF);
    wait_ready(0, w, ok);
    @(posedge clk); #1;
    wb.req_valid[0] = 1'b0;
    pend_valid[0]   = 1'b0;
    @(negedge clk);
    checkOutput("rst_seq_q0", wb.rf_write_data, 16'h000F);
    @(negedge clk);
    checkOutput("rst_seq_q1", wb.rf_write_data, 16'h000E);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_write", wb.rf_write, 0);
    checkOutput("midrst_reg", wb.rf_write_reg, 0);
    checkOutput("midrst_data", wb.rf_write_data, 0);
    checkOutput("midrst_quarter", wb.rf_quarter, 0);
    checkOutput("midrst_busy", wb.busy, 0);
    checkOutput("midrst_err", wb.err_addr, 0);
    model_last = 1;
    err_exp    = 1'b0;
    exp_mem[3][7:0] = 8'hEF;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("midrst_no_done", wb.done, 0);
    end
    checkOutput("reg3_partial", rf_mem[3], 16'h00EF);
    applyStimulus(1, 4'd3, 16'h1357, 4'hC);
    run_next(1'b0, w, p);
    checkOutput("reg3_after", rf_mem[3], 16'h13EF);

    $display("[TB] random traffic");
    for (int it = 0; it < 24; it++) begin
      for (int q = 0; q < 2; q++)
        if (!pend_valid[q] && $urandom_range(0, 1) == 1)
          applyStimulus(q, 4'($urandom_range(0, 15)), 16'($urandom), 4'($urandom));
      if (pend_valid == 2'b00)
        applyStimulus(0, 4'($urandom_range(0, 15)), 16'($urandom), 4'($urandom));
      run_next(1'b0, w, p);
    end
    for (int k = 0; k < 2 && pend_valid != 2'b00; k++) run_next(1'b0, w, p);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_wb_sequencer.md
Name: regfile_wb_sequencer

Overview:
- Write-back controller for the 8-entry, 16-bit nibble-writable register file.
- Two requesters share its single write port: port 0 is ALU writeback, port 1 is memory-load writeback.
- Arbitrates between them, latches one 16-bit write, and issues it as a sequence of nibble writes (quarter 0..3) under a nibble mask.
- Drives the register file's write, writeReg, writeData and quarter inputs directly.

Parameters:
- DATA_W, 16, register width; must equal 4*NIB_CNT.
- NIB_CNT, 4, nibbles per register, one write cycle each.
- ADDR_W, 4, register-address width; only addresses 0-7 are implemented in the register file.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  2  per-port write request; bit 0 = ALU, bit 1 = load.
- req_addr0  in  ADDR_W  port-0 target register.
- req_data0  in  DATA_W  port-0 write data.
- req_mask0  in  NIB_CNT  port-0 nibble enables; bit i enables quarter i.
- req_addr1, req_data1, req_mask1  in  ADDR_W / DATA_W / NIB_CNT  same fields for port 1.
- req_ready  out  2  per-port accept; combinational.
- done  out  2  one-cycle pulse when a port's accepted write completes.
- busy  out  1  high when not in IDLE.
- err_addr  out  1  sticky flag: an accepted request had addr >= 8.
- rf_write  out  1  register-file write strobe.
- rf_write_reg  out  ADDR_W  target register.
- rf_write_data  out  DATA_W  selected nibble in [3:0]; upper bits 0.
- rf_quarter  out  2  nibble index for the current write.

Behaviour:
- Reset (async, rst_n low): state IDLE; rf_write=0, rf_write_reg=0, rf_write_data=0, rf_quarter=0; done=0; busy=0; err_addr=0; last_grant=1, so port 0 wins first.
- Reset mid-sequence: in-flight write is abandoned. Nibbles already written stay in the register file. No done pulse.
- States:
  - IDLE: req_ready asserted only for the granted port. Grant = the only valid port; if both are valid, the port != last_grant. Accept happens at a posedge with valid&ready. On accept: latch addr/data/mask, set last_grant, go to WRITE, or to DONE if mask==0.
  - WRITE: each cycle, nib_idx = lowest set bit of the remaining mask. Drive rf_write=1, rf_quarter=nib_idx, rf_write_data={0, data[4*nib_idx+3:4*nib_idx]}. Clear that mask bit. Go to DONE when the remaining mask becomes 0.
  - DONE: rf_write=0; done[granted]=1 for exactly one cycle; return to IDLE.
- All rf_* outputs and done are registered.
- Latency from accept edge:
  - first rf_write one cycle later;
  - done pulse in cycle 1+popcount(mask);
  - next accept one cycle after done.
  - A full-mask write occupies 6 cycles accept-to-accept.
- req_ready is 0 outside IDLE. A requester holds valid and its fields stable until ready; fields are sampled only at accept.
- Addr >= 8: request is accepted and sequenced normally (the register file ignores the write). err_addr sets the cycle after accept and clears only on reset.
- mask==0: accepted, no rf_write, done one cycle after accept.
- rf_write_reg holds the latched address through WRITE; it is 0 in IDLE.
- Simultaneous valid on both ports: exactly one ready, per the round-robin rule. The loser keeps valid and is granted in the next IDLE.

Optional Feature:
- Macro WB_FIXED_PRIO_EN.
- Defined: port 1 (load) always wins when both ports are valid; last_grant is unused.
- Undefined: round-robin as described above.

Test Plan:
- Single full write: req_valid=01, addr0=2, data0=16'hA5C3, mask0=4'hF. Required: accept cycle 0; rf_write in cycles 1-4 with quarter 0,1,2,3 and data 3,C,5,A; done[0] in cycle 5; register 2 reads 16'hA5C3 afterwards.
- Sparse mask: addr1=7, data1=16'h1234, mask1=4'b1010. Required: two writes only, quarter 1 data 3 then quarter 3 data 1; done[1] in cycle 3; nibbles 0 and 2 of register 7 unchanged.
- Contention: req_valid=11 held with full masks. Required: grant order 0,1,0,1 (round-robin). With WB_FIXED_PRIO_EN: port 1 granted on every contested accept.
- mask==0 and bad address: addr0=9, mask0=0. Required: no rf_write; done[0] one cycle after accept; err_addr=1 and staying high until reset.
- Reset mid-sequence: rst_n low after the second nibble write of an F-mask request. Required: all outputs 0 immediately; no done; the first two nibbles remain written in the register file; the next request is accepted normally.
- Back-to-back: valid held on port 0 across two requests. Required: req_ready low while busy; second accept exactly one cycle after the first done.
